// File: rtl/syn_fifo.sv
// -----------------------------------------------------------------------------
// syn_fifo : single-clock synchronous FIFO with registered read data.
//
// Buffers up to DEPTH words of WIDTH bits between a producer and a consumer
// in the same clock domain.
//
// Handshake: a push is accepted on a rising edge when wpush=1 and the FIFO
// is not full, or when it is full but a pop is accepted on the same edge.
// A pop is accepted when rpop=1 and the FIFO is not empty. Requests that are
// not accepted are dropped silently; nothing is held or retried.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   wdata   in   write data, captured when a push is accepted
//   wpush   in   push request
//   wfull   out  registered, 1 when the FIFO holds DEPTH entries
//   rdata   out  registered, most recently popped word (0 after reset)
//   rpop    in   pop request
//   rempty  out  registered, 1 when the FIFO holds 0 entries
//   level   out  registered occupancy 0..DEPTH (only with SYN_FIFO_LEVEL_EN)
//
// Optional feature: define SYN_FIFO_LEVEL_EN to add the level output.
// -----------------------------------------------------------------------------
module syn_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wpush,
  output logic             wfull,
  output logic [WIDTH-1:0] rdata,
  input  logic             rpop,
  output logic             rempty
`ifdef SYN_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  // One bit wider than the pointers so DEPTH and 0 differ when wptr==rptr.
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             pop_ok;
  logic             push_ok;

  // A pop frees a slot in the same edge, so a full FIFO may still take a push.
  assign pop_ok  = rpop & ~rempty;
  assign push_ok = wpush & (~wfull | pop_ok);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage is deliberately left uncleared by reset; only the pointers and
  // occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rdata  <= '0;
      rempty <= 1'b1;
      wfull  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop_ok) begin
        rdata <= mem[rptr];
        rptr  <= rptr + PTR_ONE;
      end
      count  <= count_nxt;
      rempty <= (count_nxt == '0);
      wfull  <= (count_nxt == CNT_FULL);
    end
  end

`ifdef SYN_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_syn_fifo.sv
// -----------------------------------------------------------------------------
// tb_syn_fifo : self-checking bench for syn_fifo (WIDTH=16, DEPTH=8).
// A queue-based model tracks the expected contents and outputs; a compare
// process checks the DUT against it on every falling edge, and directed
// sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_syn_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] wdata;
  logic             wpush;
  logic             wfull;
  logic [WIDTH-1:0] rdata;
  logic             rpop;
  logic             rempty;
`ifdef SYN_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  syn_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (wdata),
    .wpush  (wpush),
    .wfull  (wfull),
    .rdata  (rdata),
    .rpop   (rpop),
    .rempty (rempty)
`ifdef SYN_FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_rdata;
  bit               model_valid = 1'b0;

  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    if (!rst_n) begin
      exp_q.delete();
      exp_rdata   = '0;
      model_valid = 1'b1;
    end else begin
      do_pop  = rpop && (exp_q.size() > 0);
      do_push = wpush && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop)  exp_rdata = exp_q.pop_front();
      if (do_push) exp_q.push_back(wdata);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cmp_rdata",  32'(rdata),  32'(exp_rdata));
      chk("cmp_rempty", 32'(rempty), 32'(exp_q.size() == 0));
      chk("cmp_wfull",  32'(wfull),  32'(exp_q.size() == DEPTH));
`ifdef SYN_FIFO_LEVEL_EN
      chk("cmp_level",  32'(level),  32'(exp_q.size()));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    wpush = p;
    rpop  = q;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, '0);
    rst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] fill_words [8] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                                       16'h5678, 16'h6789, 16'h789A, 16'h89AB};

  initial begin
    rst_n = 1'b1;
    wpush = 1'b0;
    rpop  = 1'b0;
    wdata = '0;

    // Reset state
    do_reset();
    chk("rst_rdata",  32'(rdata),  32'h0);
    chk("rst_rempty", 32'(rempty), 32'h1);
    chk("rst_wfull",  32'(wfull),  32'h0);

    // Fill 8
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, fill_words[i]);
      if (i == 0) chk("fill_first_rempty", 32'(rempty), 32'h0);
      if (i == 6) chk("fill_7_wfull", 32'(wfull), 32'h0);
    end
    chk("fill_wfull", 32'(wfull), 32'h1);

    // Push while full without pop: ignored
    step(1'b1, 1'b0, 16'hAAAA);
    chk("full_push_wfull", 32'(wfull), 32'h1);

    // Drain 8: original order, 0xAAAA never appears
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("drain_rdata", 32'(rdata), 32'(fill_words[i]));
      if (i == 0) chk("drain_first_wfull", 32'(wfull), 32'h0);
    end
    chk("drain_rempty", 32'(rempty), 32'h1);

    // Pop while empty: rdata holds
    step(1'b0, 1'b1, '0);
    chk("empty_pop_rdata",  32'(rdata),  32'h89AB);
    chk("empty_pop_rempty", 32'(rempty), 32'h1);

    // Push+pop while empty: push only
    step(1'b1, 1'b1, 16'hBEEF);
    chk("empty_pp_rdata",  32'(rdata),  32'h89AB);
    chk("empty_pp_rempty", 32'(rempty), 32'h0);
    step(1'b0, 1'b1, '0);
    chk("empty_pp_pop", 32'(rdata), 32'hBEEF);
    chk("empty_pp_pop_rempty", 32'(rempty), 32'h1);

    // Streaming with wrap: 4 pushes, 8 push+pop, 4 pops
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'hC000 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 16'hC004 + 16'(i));
      chk("stream_rdata", 32'(rdata), 32'h0000C000 + 32'(i));
      chk("stream_wfull", 32'(wfull), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, '0);
      chk("stream_tail_rdata", 32'(rdata), 32'h0000C008 + 32'(i));
    end
    chk("stream_rempty", 32'(rempty), 32'h1);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h7700 + 16'(i));
    step(1'b1, 1'b1, 16'h7704);
    step(1'b1, 1'b1, 16'h7705);
    chk("mid_pre_rdata", 32'(rdata), 32'h7701);
    do_reset();
    chk("mid_rst_rdata",  32'(rdata),  32'h0);
    chk("mid_rst_rempty", 32'(rempty), 32'h1);
    chk("mid_rst_wfull",  32'(wfull),  32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'hD000 + 16'(i));
    chk("mid_fill_wfull", 32'(wfull), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("mid_drain_rdata", 32'(rdata), 32'h0000D000 + 32'(i));
    end
    chk("mid_drain_rempty", 32'(rempty), 32'h1);

    // Full with simultaneous push+pop
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'hE000 + 16'(i));
    step(1'b1, 1'b1, 16'h5555);
    chk("full_pp_rdata", 32'(rdata), 32'hE000);
    chk("full_pp_wfull", 32'(wfull), 32'h1);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk("full_pp_drain", 32'(rdata), 32'h0000E000 + 32'(i));
    end
    step(1'b0, 1'b1, '0);
    chk("full_pp_last", 32'(rdata), 32'h5555);
    chk("full_pp_rempty", 32'(rempty), 32'h1);

    step(1'b0, 1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
